spmv_issue_ctrl: RTL and testbench

//  Issue scheduler for the 4-lane sparse MAC pipeline (multiply, map-table and adder levels).

---
 rtl/spmv_issue_ctrl_pkg.sv | 40 ++++
 rtl/spmv_issue_ctrl_if.sv | 44 ++++
 rtl/spmv_lat_pipe.sv | 45 ++++
 rtl/spmv_issue_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_spmv_issue_ctrl.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spmv_issue_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// spmv_issue_ctrl_pkg
// Shared constants, state encoding and lane helpers for the 4-lane sparse MAC
// pipeline: the issue scheduler and the datapath levels import this package.
//   K       lanes per beat (lane 0 sits in the MSB slice of each packed bus)
//   LAT     cycles from a beat issue to its result
//   MAT_W   width of one matrix/vector element
//   ONES_W  width of the row-end popcount bus
// -----------------------------------------------------------------------------
package spmv_issue_ctrl_pkg;

   localparam int K      = 4;
   localparam int LAT    = 4;
   localparam int MAT_W  = 8;
   localparam int ONES_W = 5;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FILL  = 3'd1,
      ST_ISSUE = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   // LSB position of a lane's slice inside a packed K*MAT_W bus.
   function automatic int lane_lsb(input int lane);
      return (K - 1 - lane) * MAT_W;
   endfunction

   // Number of lanes in a beat that close a row.
   function automatic logic [ONES_W-1:0] popcount(input logic [K-1:0] v);
      logic [ONES_W-1:0] n;
      n = '0;
      for (int i = 0; i < K; i++) begin
         n = n + ONES_W'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/spmv_issue_ctrl_if.sv
// -----------------------------------------------------------------------------
// spmv_issue_ctrl_if
// Job control, element stream, issue bus, result strobe and credit return of
// the sparse MAC issue scheduler.
//   master : upstream/job controller side (drives start, elements, credits)
//   slave  : scheduler side (drives busy/done, in_ready, iss_*, res_*)
// -----------------------------------------------------------------------------
interface spmv_issue_ctrl_if
   import spmv_issue_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) ();

   logic                    start;
   logic [CNT_W-1:0]        num_nz;
   logic                    busy;
   logic                    done;
   logic                    in_valid;
   logic                    in_ready;
   logic signed [MAT_W-1:0] in_mat;
   logic signed [MAT_W-1:0] in_vec;
   logic                    in_row_end;
   logic                    iss_valid;
   logic [MAT_W*K-1:0]      iss_matrix;
   logic [MAT_W*K-1:0]      iss_vector;
   logic [K-1:0]            iss_ipv;
   logic [ONES_W-1:0]       iss_ones;
   logic                    res_valid;
   logic                    res_last;
   logic                    credit_ret;

   modport master (
      output start, num_nz, in_valid, in_mat, in_vec, in_row_end, credit_ret,
      input  busy, done, in_ready, iss_valid, iss_matrix, iss_vector,
             iss_ipv, iss_ones, res_valid, res_last
   );

   modport slave (
      input  start, num_nz, in_valid, in_mat, in_vec, in_row_end, credit_ret,
      output busy, done, in_ready, iss_valid, iss_matrix, iss_vector,
             iss_ipv, iss_ones, res_valid, res_last
   );

endinterface

// File: rtl/spmv_lat_pipe.sv
// -----------------------------------------------------------------------------
// spmv_lat_pipe
// DEPTH-deep shift register carrying a valid bit and its last qualifier,
// modelling the MAC pipeline register depth (also used by the accumulator).
//   clk, rst  clock, synchronous active-low reset (clears every stage)
//   i_valid   valid entering the pipe
//   i_last    last qualifier entering the pipe
//   o_valid   valid leaving the pipe DEPTH cycles later
//   o_last    last qualifier leaving the pipe (only set with o_valid)
//   o_busy    any stage currently holds a valid bit
// -----------------------------------------------------------------------------
module spmv_lat_pipe #(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_valid,
   input  logic i_last,
   output logic o_valid,
   output logic o_last,
   output logic o_busy
);

   logic [DEPTH-1:0] r_valid;
   logic [DEPTH-1:0] r_last;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_valid <= '0;
         r_last  <= '0;
      end else begin
         r_valid[0] <= i_valid;
         r_last[0]  <= i_valid & i_last;
         for (int i = 1; i < DEPTH; i++) begin
            r_valid[i] <= r_valid[i-1];
            r_last[i]  <= r_last[i-1];
         end
      end
   end

   assign o_valid = r_valid[DEPTH-1];
   assign o_last  = r_last[DEPTH-1];
   assign o_busy  = |r_valid;

endmodule

// File: rtl/spmv_issue_ctrl.sv
// -----------------------------------------------------------------------------
// spmv_issue_ctrl
// Issue scheduler for the 4-lane sparse MAC pipeline. Packs a stream of
// (matrix, vector, row_end) nonzeros into K-lane beats, issues each beat only
// when a downstream result-FIFO credit is available, tracks in-flight beats
// through a LAT-deep delay line and pulses done after the final result.
//   clk          clock
//   rst          synchronous active-low reset; aborts any job
//   bus (slave)  start/num_nz/busy/done job control,
//                in_valid/in_ready/in_mat/in_vec/in_row_end element stream,
//                iss_valid/iss_matrix/iss_vector/iss_ipv/iss_ones beat bus,
//                res_valid/res_last result strobe, credit_ret credit return
// -----------------------------------------------------------------------------
module spmv_issue_ctrl
   import spmv_issue_ctrl_pkg::*;
#(
   parameter int CREDITS = 8,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   spmv_issue_ctrl_if.slave bus
);

   localparam int CRD_W  = $clog2(CREDITS + 1);
   localparam int LANE_W = $clog2(K);

   state_e                      r_state;
   logic [CNT_W-1:0]            r_num_nz;
   logic [CNT_W-1:0]            r_cnt;
   logic [LANE_W-1:0]           r_lane;
   logic [K-1:0][MAT_W-1:0]     r_mat;
   logic [K-1:0][MAT_W-1:0]     r_vec;
   logic [K-1:0]                r_ipv;
   logic                        r_busy;
   logic                        r_done;
   logic                        r_in_ready;
   logic                        r_iss_valid;
   logic                        r_iss_last;
   logic [MAT_W*K-1:0]          r_iss_matrix;
   logic [MAT_W*K-1:0]          r_iss_vector;
   logic [K-1:0]                r_iss_ipv;
   logic [ONES_W-1:0]           r_iss_ones;
   logic [CRD_W-1:0]            r_credits;

   logic                        w_accept;
   logic [CNT_W-1:0]            w_cnt_inc;
   logic                        w_last_elem;
   logic                        w_job_done;
   logic [LANE_W-1:0]           w_ipv_bit;
   logic                        w_can_issue;
   logic                        w_issue;
   logic [MAT_W*K-1:0]          w_mat_pack;
   logic [MAT_W*K-1:0]          w_vec_pack;
   logic                        w_res_valid;
   logic                        w_res_last;
   logic                        w_pipe_busy;

   assign w_accept    = r_in_ready & bus.in_valid;
   assign w_cnt_inc   = r_cnt + 1'b1;
   assign w_last_elem = (w_cnt_inc == r_num_nz);
   assign w_job_done  = (r_cnt == r_num_nz);
   // Lane i reports its row end on ipv bit K-1-i.
   assign w_ipv_bit   = LANE_W'(K - 1) - r_lane;
   // A credit returned this cycle can be spent by the same cycle's issue.
   assign w_can_issue = (r_credits != '0) | bus.credit_ret;
   assign w_issue     = (r_state == ST_ISSUE) & w_can_issue;

   for (genvar g = 0; g < K; g++) begin : g_pack
      assign w_mat_pack[lane_lsb(g) +: MAT_W] = r_mat[g];
      assign w_vec_pack[lane_lsb(g) +: MAT_W] = r_vec[g];
   end

   // ---- control FSM / lane buffer / issue register ----
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_num_nz     <= '0;
         r_cnt        <= '0;
         r_lane       <= '0;
         r_mat        <= '0;
         r_vec        <= '0;
         r_ipv        <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_in_ready   <= 1'b0;
         r_iss_valid  <= 1'b0;
         r_iss_last   <= 1'b0;
         r_iss_matrix <= '0;
         r_iss_vector <= '0;
         r_iss_ipv    <= '0;
         r_iss_ones   <= '0;
      end else begin
         r_done      <= 1'b0;
         r_iss_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_busy   <= 1'b1;
                  r_num_nz <= bus.num_nz;
                  r_cnt    <= '0;
                  r_lane   <= '0;
                  r_mat    <= '0;
                  r_vec    <= '0;
                  r_ipv    <= '0;
                  if (bus.num_nz != '0) begin
                     r_state    <= ST_FILL;
                     r_in_ready <= 1'b1;
                  end else begin
                     r_state <= ST_DONE;
                  end
               end
            end
            ST_FILL: begin
               if (w_accept) begin
                  r_mat[r_lane]    <= bus.in_mat;
                  r_vec[r_lane]    <= bus.in_vec;
                  // The job's final element always closes its row.
                  r_ipv[w_ipv_bit] <= bus.in_row_end | w_last_elem;
                  r_lane           <= r_lane + 1'b1;
                  r_cnt            <= w_cnt_inc;
                  if ((r_lane == LANE_W'(K - 1)) || w_last_elem) begin
                     r_state    <= ST_ISSUE;
                     r_in_ready <= 1'b0;
                  end
               end
            end
            ST_ISSUE: begin
               // Without a credit the beat stays buffered and iss_* hold.
               if (w_can_issue) begin
                  r_iss_valid  <= 1'b1;
                  r_iss_last   <= w_job_done;
                  r_iss_matrix <= w_mat_pack;
                  r_iss_vector <= w_vec_pack;
                  r_iss_ipv    <= r_ipv;
                  r_iss_ones   <= popcount(r_ipv);
                  r_lane       <= '0;
                  r_mat        <= '0;
                  r_vec        <= '0;
                  r_ipv        <= '0;
                  if (w_job_done) begin
                     r_state <= ST_DRAIN;
                  end else begin
                     r_state    <= ST_FILL;
                     r_in_ready <= 1'b1;
                  end
               end
            end
            ST_DRAIN: begin
               // The beat just issued has not entered the delay line yet.
               if (!r_iss_valid && !w_pipe_busy) begin
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // ---- result-FIFO credit counter ----
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_credits <= CRD_W'(CREDITS);
      end else if (w_issue && !bus.credit_ret) begin
         r_credits <= r_credits - 1'b1;
      end else if (!w_issue && bus.credit_ret && (r_credits != CRD_W'(CREDITS))) begin
         r_credits <= r_credits + 1'b1;
      end
   end

   // ---- LAT-deep in-flight tracking ----
   spmv_lat_pipe #(
      .DEPTH (LAT)
   ) u_lat_pipe (
      .clk     (clk),
      .rst     (rst),
      .i_valid (r_iss_valid),
      .i_last  (r_iss_last),
      .o_valid (w_res_valid),
      .o_last  (w_res_last),
      .o_busy  (w_pipe_busy)
   );

   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.in_ready   = r_in_ready;
   assign bus.iss_valid  = r_iss_valid;
   assign bus.iss_matrix = r_iss_matrix;
   assign bus.iss_vector = r_iss_vector;
   assign bus.iss_ipv    = r_iss_ipv;
   assign bus.iss_ones   = r_iss_ones;
   assign bus.res_valid  = w_res_valid;
   assign bus.res_last   = w_res_last;

endmodule

// File: tb/tb_spmv_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spmv_issue_ctrl
// Directed bench for spmv_issue_ctrl. Two instances share the stimulus
// variables through a select: dut_a has the default 8 credits, dut_b has a
// single credit for the stall scenario.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spmv_issue_ctrl;
   import spmv_issue_ctrl_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        t_sel;
   logic        t_start;
   logic [15:0] t_num_nz;
   logic        t_in_valid;
   logic [7:0]  t_in_mat;
   logic [7:0]  t_in_vec;
   logic        t_in_row_end;
   logic        t_credit_ret;

   spmv_issue_ctrl_if #(.CNT_W(16)) if_a ();
   spmv_issue_ctrl_if #(.CNT_W(16)) if_b ();

   spmv_issue_ctrl #(.CREDITS(8), .CNT_W(16)) u_dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
   spmv_issue_ctrl #(.CREDITS(1), .CNT_W(16)) u_dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

   assign if_a.start      = t_start & ~t_sel;
   assign if_a.num_nz     = t_num_nz;
   assign if_a.in_valid   = t_in_valid & ~t_sel;
   assign if_a.in_mat     = t_in_mat;
   assign if_a.in_vec     = t_in_vec;
   assign if_a.in_row_end = t_in_row_end;
   assign if_a.credit_ret = t_credit_ret & ~t_sel;
   assign if_b.start      = t_start & t_sel;
   assign if_b.num_nz     = t_num_nz;
   assign if_b.in_valid   = t_in_valid & t_sel;
   assign if_b.in_mat     = t_in_mat;
   assign if_b.in_vec     = t_in_vec;
   assign if_b.in_row_end = t_in_row_end;
   assign if_b.credit_ret = t_credit_ret & t_sel;

   logic        m_busy, m_done, m_in_ready, m_iss_valid, m_res_valid, m_res_last;
   logic [31:0] m_iss_matrix, m_iss_vector;
   logic [3:0]  m_iss_ipv;
   logic [4:0]  m_iss_ones;
   assign m_busy       = t_sel ? if_b.busy       : if_a.busy;
   assign m_done       = t_sel ? if_b.done       : if_a.done;
   assign m_in_ready   = t_sel ? if_b.in_ready   : if_a.in_ready;
   assign m_iss_valid  = t_sel ? if_b.iss_valid  : if_a.iss_valid;
   assign m_iss_matrix = t_sel ? if_b.iss_matrix : if_a.iss_matrix;
   assign m_iss_vector = t_sel ? if_b.iss_vector : if_a.iss_vector;
   assign m_iss_ipv    = t_sel ? if_b.iss_ipv    : if_a.iss_ipv;
   assign m_iss_ones   = t_sel ? if_b.iss_ones   : if_a.iss_ones;
   assign m_res_valid  = t_sel ? if_b.res_valid  : if_a.res_valid;
   assign m_res_last   = t_sel ? if_b.res_last   : if_a.res_last;

   // Cycle index; an output seen at a falling edge belongs to cycle cyc.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] b_mat [64];
   logic [31:0] b_vec [64];
   logic [3:0]  b_ipv [64];
   logic [4:0]  b_ones[64];
   int          b_cyc [64];
   int          res_cyc[64];
   int          n_beat = 0, n_res = 0, n_last = 0, n_done = 0;
   int          last_cyc = 0, done_cyc = 0;

   always @(negedge clk) begin
      if (m_iss_valid && n_beat < 64) begin
         b_mat[n_beat]  <= m_iss_matrix;
         b_vec[n_beat]  <= m_iss_vector;
         b_ipv[n_beat]  <= m_iss_ipv;
         b_ones[n_beat] <= m_iss_ones;
         b_cyc[n_beat]  <= cyc;
         n_beat         <= n_beat + 1;
      end
      if (m_res_valid && n_res < 64) begin
         res_cyc[n_res] <= cyc;
         n_res          <= n_res + 1;
      end
      if (m_res_valid && m_res_last) begin
         last_cyc <= cyc;
         n_last   <= n_last + 1;
      end
      if (m_done) begin
         done_cyc <= cyc;
         n_done   <= n_done + 1;
      end
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic start_job(input logic [15:0] n, output int scyc);
      t_start  = 1'b1;
      t_num_nz = n;
      scyc     = cyc;
      @(negedge clk);
      t_start  = 1'b0;
   endtask

   task automatic send(input logic [7:0] m, input logic [7:0] v, input logic re);
      int b = 0;
      t_in_valid   = 1'b1;
      t_in_mat     = m;
      t_in_vec     = v;
      t_in_row_end = re;
      while (m_in_ready !== 1'b1 && b < 40) begin
         @(negedge clk);
         b++;
      end
      if (b >= 40) chk("in_ready_timeout", {31'd0, m_in_ready}, 32'd1);
      @(negedge clk);
      t_in_valid   = 1'b0;
      t_in_row_end = 1'b0;
   endtask

   task automatic wait_done(input int d0, input string tag);
      int b = 0;
      while (n_done == d0 && b < 200) begin
         @(negedge clk);
         b++;
      end
      repeat (2) @(negedge clk);
      chk(tag, n_done - d0, 32'd1);
   endtask

   // Elements (1,2),(3,4),(-5,6),(7,-8).
   task automatic send_t1(input int gap, input logic re_last);
      send(8'h01, 8'h02, 1'b0); repeat (gap) @(negedge clk);
      send(8'h03, 8'h04, 1'b0); repeat (gap) @(negedge clk);
      send(8'hFB, 8'h06, 1'b0); repeat (gap) @(negedge clk);
      send(8'h07, 8'hF8, re_last);
   endtask

   task automatic check_t1(input string p, input int b0, input int r0, input int l0);
      chk({p, "_nbeat"}, n_beat - b0, 32'd1);
      chk({p, "_matrix"}, b_mat[b0], 32'h0103FB07);
      chk({p, "_vector"}, b_vec[b0], 32'h020406F8);
      chk({p, "_ipv"}, {28'd0, b_ipv[b0]}, 32'h1);
      chk({p, "_ones"}, {27'd0, b_ones[b0]}, 32'd1);
      chk({p, "_res_lat"}, res_cyc[r0] - b_cyc[b0], 32'd4);
      chk({p, "_nlast"}, n_last - l0, 32'd1);
      chk({p, "_last_lat"}, last_cyc - b_cyc[b0], 32'd4);
      chk({p, "_done_after_res"}, {31'd0, (done_cyc > last_cyc) && (done_cyc <= last_cyc + 3)}, 32'd1);
      chk({p, "_busy_off"}, {31'd0, m_busy}, 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int b0, r0, l0, d0, s, pc, bw;
      rst = 1'b0;
      t_sel = 1'b0; t_start = 1'b0; t_num_nz = '0; t_in_valid = 1'b0;
      t_in_mat = '0; t_in_vec = '0; t_in_row_end = 1'b0; t_credit_ret = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, m_busy}, 32'd0);
      chk("rst_done", {31'd0, m_done}, 32'd0);
      chk("rst_in_ready", {31'd0, m_in_ready}, 32'd0);
      chk("rst_iss_valid", {31'd0, m_iss_valid}, 32'd0);
      chk("rst_iss_matrix", m_iss_matrix, 32'd0);
      chk("rst_res_valid", {31'd0, m_res_valid}, 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Single full beat.
      b0 = n_beat; r0 = n_res; l0 = n_last; d0 = n_done;
      start_job(16'd4, s);
      send_t1(0, 1'b1);
      chk("t1_busy_on", {31'd0, m_busy}, 32'd1);
      wait_done(d0, "t1_done_seen");
      check_t1("t1", b0, r0, l0);

      // Two beats, rows closing in lane 1 of each; second beat half padded.
      b0 = n_beat; r0 = n_res; l0 = n_last; d0 = n_done;
      start_job(16'd6, s);
      send(8'h0B, 8'hFF, 1'b0);
      send(8'h0C, 8'hFE, 1'b1);
      send(8'h0D, 8'hFD, 1'b0);
      send(8'h0E, 8'hFC, 1'b0);
      send(8'h0F, 8'hFB, 1'b0);
      send(8'h10, 8'hFA, 1'b1);
      wait_done(d0, "t2_done_seen");
      chk("t2_nbeat", n_beat - b0, 32'd2);
      chk("t2_b1_matrix", b_mat[b0], 32'h0B0C0D0E);
      chk("t2_b1_vector", b_vec[b0], 32'hFFFEFDFC);
      chk("t2_b1_ipv", {28'd0, b_ipv[b0]}, 32'h4);
      chk("t2_b1_ones", {27'd0, b_ones[b0]}, 32'd1);
      chk("t2_b2_matrix", b_mat[b0+1], 32'h0F100000);
      chk("t2_b2_vector", b_vec[b0+1], 32'hFBFA0000);
      chk("t2_b2_ipv", {28'd0, b_ipv[b0+1]}, 32'h4);
      chk("t2_b2_ones", {27'd0, b_ones[b0+1]}, 32'd1);
      chk("t2_nres", n_res - r0, 32'd2);
      chk("t2_nlast", n_last - l0, 32'd1);

      // Empty job.
      b0 = n_beat; r0 = n_res; d0 = n_done;
      start_job(16'd0, s);
      wait_done(d0, "t4_done_seen");
      chk("t4_done_cycle", done_cyc - s, 32'd2);
      chk("t4_no_issue", n_beat - b0, 32'd0);
      chk("t4_no_res", n_res - r0, 32'd0);

      // Gapped input, final row_end left to the forcing logic.
      b0 = n_beat; r0 = n_res; l0 = n_last; d0 = n_done;
      start_job(16'd4, s);
      send_t1(3, 1'b0);
      wait_done(d0, "t5_done_seen");
      check_t1("t5", b0, r0, l0);

      // Single-credit instance: second beat waits for a returned credit.
      t_sel = 1'b1;
      @(negedge clk);
      b0 = n_beat; d0 = n_done;
      start_job(16'd8, s);
      for (int i = 1; i <= 8; i++) send(8'(i), 8'(i), 1'b0);
      repeat (6) @(negedge clk);
      chk("t3_stalled", n_beat - b0, 32'd1);
      chk("t3_busy_stall", {31'd0, m_busy}, 32'd1);
      t_credit_ret = 1'b1;
      pc = cyc;
      @(negedge clk);
      t_credit_ret = 1'b0;
      wait_done(d0, "t3_done_seen");
      chk("t3_nbeat", n_beat - b0, 32'd2);
      chk("t3_b1_matrix", b_mat[b0], 32'h01020304);
      chk("t3_b2_matrix", b_mat[b0+1], 32'h05060708);
      chk("t3_b2_ipv", {28'd0, b_ipv[b0+1]}, 32'h1);
      chk("t3_issue_after_credit", b_cyc[b0+1] - pc, 32'd1);
      t_sel = 1'b0;
      @(negedge clk);

      // Reset while a beat is in flight.
      r0 = n_res; d0 = n_done;
      start_job(16'd4, s);
      send_t1(0, 1'b1);
      bw = 0;
      while (m_iss_valid !== 1'b1 && bw < 10) begin
         @(negedge clk);
         bw++;
      end
      chk("t6_iss_seen", {31'd0, m_iss_valid}, 32'd1);
      rst = 1'b0;
      @(negedge clk);
      chk("t6_rst_iss_valid", {31'd0, m_iss_valid}, 32'd0);
      chk("t6_rst_iss_matrix", m_iss_matrix, 32'd0);
      chk("t6_rst_iss_ipv", {28'd0, m_iss_ipv}, 32'd0);
      chk("t6_rst_busy", {31'd0, m_busy}, 32'd0);
      chk("t6_rst_in_ready", {31'd0, m_in_ready}, 32'd0);
      rst = 1'b1;
      repeat (LAT + 4) @(negedge clk);
      chk("t6_no_res", n_res - r0, 32'd0);
      chk("t6_no_done", n_done - d0, 32'd0);
      b0 = n_beat; r0 = n_res; l0 = n_last; d0 = n_done;
      start_job(16'd4, s);
      send_t1(0, 1'b1);
      wait_done(d0, "t6b_done_seen");
      check_t1("t6b", b0, r0, l0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
